// File: rtl/trig_pkg.sv
// Shared constants, state codes and float helpers for the trig angle sequencer.
package trig_pkg;

    localparam int REDUCE_STEPS = 24;

    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [31:0] FP_ONE      = 32'h3F80_0000;
    localparam int          FP_SIGN_BIT = 31;

    localparam logic [31:0] DEG_90  = 32'd90;
    localparam logic [31:0] DEG_180 = 32'd180;
    localparam logic [31:0] DEG_270 = 32'd270;
    localparam logic [31:0] DEG_360 = 32'd360;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_REDUCE   = 3'd1;
    localparam state_t S_FOLD     = 3'd2;
    localparam state_t S_SIN_REQ  = 3'd3;
    localparam state_t S_SIN_WAIT = 3'd4;
    localparam state_t S_COS_REQ  = 3'd5;
    localparam state_t S_COS_WAIT = 3'd6;
    localparam state_t S_DONE     = 3'd7;

    // Table endpoints are exact constants; the table word is only trusted inside
    function automatic logic [31:0] lut_mag(
        input logic [31:0] ang,
        input logic [31:0] val
    );
        logic [31:0] m;
        if (ang == 32'd0)
            m = FP_ZERO;
        else if (ang == DEG_90)
            m = FP_ONE;
        else
            m = {1'b0, val[FP_SIGN_BIT-1:0]};
        return m;
    endfunction

    // A zero magnitude never carries a sign, so -0.0 cannot appear
    function automatic logic [31:0] with_sign(
        input logic        neg,
        input logic [31:0] mag
    );
        logic [31:0] w;
        if (mag == FP_ZERO)
            w = FP_ZERO;
        else
            w = {neg, mag[FP_SIGN_BIT-1:0]};
        return w;
    endfunction

endpackage

// File: rtl/trig_angle_seq_if.sv
// Angle-in / float-out valid-ready bundle of the trig sequencer.
// out_cos exists only when TRIG_COS_EN is defined.
interface trig_angle_seq_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_angle;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sin;
`ifdef TRIG_COS_EN
    logic [DATA_W-1:0] out_cos;
`endif

    modport master (
        output in_valid, in_angle, out_ready,
`ifdef TRIG_COS_EN
        input  out_cos,
`endif
        input  in_ready, out_valid, out_sin
    );

    modport slave (
        input  in_valid, in_angle, out_ready,
`ifdef TRIG_COS_EN
        output out_cos,
`endif
        output in_ready, out_valid, out_sin
    );

endinterface

// File: rtl/angle_mod360.sv
// Iterative mod-360 reducer: one conditional subtract of 360<<k per cycle.
// done marks the cycle in which the final (k=0) step is applied.
module angle_mod360
    import trig_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int STEPS  = REDUCE_STEPS,
    localparam int KW    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] angle,
    output logic              done,
    output logic [DATA_W-1:0] r
);

    logic [KW-1:0]     k;
    logic              run;
    logic [DATA_W-1:0] sub;

    assign sub  = DATA_W'(DEG_360) << k;
    assign done = run && (k == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r   <= '0;
            k   <= '0;
            run <= 1'b0;
        end else if (start) begin
            r   <= angle;
            k   <= KW'(STEPS - 1);
            run <= 1'b1;
        end else if (run) begin
            if (r >= sub)
                r <= r - sub;
            if (k == '0)
                run <= 1'b0;
            else
                k <= k - 1'b1;
        end
    end

endmodule

// File: rtl/trig_angle_seq.sv
// Sine-table front end: mod-360 reduce, quadrant fold, table sequencing, sign restore.
// Define TRIG_COS_EN to add the cosine lookup and the out_cos output.
module trig_angle_seq
    import trig_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int LUT_LAT      = 1,
    parameter int REDUCE_STEPS = trig_pkg::REDUCE_STEPS
) (
    input  logic              clk,
    input  logic              rst_n,
    trig_angle_seq_if.slave   bus,
    output logic [DATA_W-1:0] lut_angle,
    input  logic [DATA_W-1:0] lut_value,
    output logic              busy
);

    state_t            state;
    logic [DATA_W-1:0] a;
    logic              ss;
    logic [7:0]        wcnt;
    logic              accept;
    logic              red_done;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] fa;
    logic              fss;
    logic [DATA_W-1:0] sin_word;
`ifdef TRIG_COS_EN
    logic              cs;
    logic              fcs;
    logic [DATA_W-1:0] cos_word;
`endif

    assign bus.in_ready = (state == S_IDLE) && rst_n;
    assign accept       = bus.in_valid && bus.in_ready;
    assign busy         = (state != S_IDLE);

    angle_mod360 #(
        .DATA_W (DATA_W),
        .STEPS  (REDUCE_STEPS)
    ) u_mod (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .angle  (bus.in_angle),
        .done   (red_done),
        .r      (r)
    );

    // Fold 0..359 into the table's 0..90 domain, keeping quadrant signs
    always_comb begin
        fa  = r;
        fss = 1'b0;
`ifdef TRIG_COS_EN
        fcs = 1'b0;
`endif
        unique case (1'b1)
            (r <= DEG_90): begin
                fa = r;
            end
            (r > DEG_90 && r <= DEG_180): begin
                fa = DEG_180 - r;
`ifdef TRIG_COS_EN
                fcs = 1'b1;
`endif
            end
            (r > DEG_180 && r <= DEG_270): begin
                fa  = r - DEG_180;
                fss = 1'b1;
`ifdef TRIG_COS_EN
                fcs = 1'b1;
`endif
            end
            (r > DEG_270): begin
                fa  = DEG_360 - r;
                fss = 1'b1;
            end
        endcase
    end

    assign sin_word = with_sign(ss, lut_mag(a, lut_value));
`ifdef TRIG_COS_EN
    assign cos_word = with_sign(cs, lut_mag(DEG_90 - a, lut_value));
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            a             <= '0;
            ss            <= 1'b0;
            wcnt          <= '0;
            lut_angle     <= '0;
            bus.out_valid <= 1'b0;
            bus.out_sin   <= '0;
`ifdef TRIG_COS_EN
            cs            <= 1'b0;
            bus.out_cos   <= '0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept)
                        state <= S_REDUCE;
                end
                S_REDUCE: begin
                    if (red_done)
                        state <= S_FOLD;
                end
                S_FOLD: begin
                    a         <= fa;
                    ss        <= fss;
`ifdef TRIG_COS_EN
                    cs        <= fcs;
`endif
                    lut_angle <= fa;
                    state     <= S_SIN_REQ;
                end
                S_SIN_REQ: begin
                    wcnt  <= 8'(LUT_LAT - 1);
                    state <= S_SIN_WAIT;
                end
                S_SIN_WAIT: begin
                    if (wcnt == '0) begin
                        bus.out_sin <= sin_word;
`ifdef TRIG_COS_EN
                        lut_angle   <= DEG_90 - a;
                        state       <= S_COS_REQ;
`else
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
`endif
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
`ifdef TRIG_COS_EN
                S_COS_REQ: begin
                    wcnt  <= 8'(LUT_LAT - 1);
                    state <= S_COS_WAIT;
                end
                S_COS_WAIT: begin
                    if (wcnt == '0) begin
                        bus.out_cos   <= cos_word;
                        bus.out_valid <= 1'b1;
                        state         <= S_DONE;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trig_angle_seq.sv
// Bench for trig_angle_seq: registered table model
// and degree-level reference; cos when TRIG_COS_EN.
module tb_trig_angle_seq;

`ifdef TRIG_COS_EN
  localparam int LAT = 29;
`else
  localparam int LAT = 27;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] lut_angle;
  logic [31:0] lut_value = 32'h0;
  logic        busy;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  trig_angle_seq_if #(.DATA_W(32)) bus ();

  trig_angle_seq #(
    .DATA_W       (32),
    .LUT_LAT      (1),
    .REDUCE_STEPS (24)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .lut_angle (lut_angle),
    .lut_value (lut_value),
    .busy      (busy)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    if (obs !== exp) begin
      fails++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lutf(
    input logic [31:0] x
  );
    logic [31:0] v;
    if (x == 32'd30)
      v = 32'h3F00_0000;
    else if (x == 32'd60)
      v = 32'h3F5D_B3D7;
    else if (x == 32'd0 || x == 32'd90)
      v = 32'hDEAD_BEEF;
    else if (x == 32'd7)
      v = 32'h8000_0000;
    else
      v = {x[0], 8'h7D, x[6:0], 16'h5A5A};
    return v;
  endfunction

  always @(posedge clk)
    lut_value <= lutf(lut_angle);

  function automatic logic [31:0] mag(
    input logic [31:0] x
  );
    if (x == 32'd0)
      return 32'h0;
    if (x == 32'd90)
      return 32'h3F80_0000;
    return lutf(x) & 32'h7FFF_FFFF;
  endfunction

  function automatic logic [31:0] signed_word(
    input logic        neg,
    input logic [31:0] m
  );
    if (m == 32'h0)
      return 32'h0;
    return m | (neg ? 32'h8000_0000 : 32'h0);
  endfunction

  function automatic logic [31:0] ref_fold(
    input logic [31:0] ang
  );
    logic [31:0] m;
    m = (ang % 32'd360) % 32'd180;
    return (m <= 32'd90) ? m : (32'd180 - m);
  endfunction

  function automatic logic [31:0] ref_sin(
    input logic [31:0] ang
  );
    logic [31:0] d;
    d = ang % 32'd360;
    return signed_word(d > 32'd180,
                       mag(ref_fold(ang)));
  endfunction

  function automatic logic [31:0] ref_cos(
    input logic [31:0] ang
  );
    logic [31:0] d;
    d = ang % 32'd360;
    return signed_word(
      d > 32'd90 && d < 32'd270,
      mag(32'd90 - ref_fold(ang)));
  endfunction

  task automatic start_and_wait(
    input logic [31:0] ang
  );
    int n;
    logic [31:0] ea;
    ea = ref_fold(ang);
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait_expired",
        32'(n < 100), 32'd1);
    chk("in_ready_before_accept",
        bus.in_ready, 1'b1);
    bus.in_angle = ang;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 80) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 26)
        chk("lut_angle_sin", lut_angle, ea);
`ifdef TRIG_COS_EN
      if (n == 28)
        chk("lut_angle_cos", lut_angle,
            32'd90 - ea);
`endif
    end
    chk("latency", n, LAT);
    chk("out_sin", bus.out_sin, ref_sin(ang));
`ifdef TRIG_COS_EN
    chk("out_cos", bus.out_cos, ref_cos(ang));
`endif
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("out_valid_after_hs",
        bus.out_valid, 1'b0);
    chk("in_ready_after_hs",
        bus.in_ready, 1'b1);
  endtask

  task automatic run_one(input logic [31:0] ang);
    start_and_wait(ang);
    handshake();
  endtask

  initial begin
    logic [31:0] held;
    logic        stable;
    bus.in_valid  = 1'b0;
    bus.in_angle  = 32'h0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_out_sin", bus.out_sin, 32'h0);
    chk("rst_lut_angle", lut_angle, 32'h0);
`ifdef TRIG_COS_EN
    chk("rst_out_cos", bus.out_cos, 32'h0);
`endif
    rst_n = 1'b1;
    #1;
    chk("in_ready_out_of_rst",
        bus.in_ready, 1'b1);

    run_one(32'd30);
    chk("sin30_const", bus.out_sin,
        32'h3F00_0000);
    run_one(32'd210);
    chk("sin210_const", bus.out_sin,
        32'hBF00_0000);
    run_one(32'd90);
    chk("sin90_const", bus.out_sin,
        32'h3F80_0000);
    run_one(32'd180);
    chk("sin180_const", bus.out_sin, 32'h0);
    run_one(32'hFFFF_FFFF);
    run_one(32'd360);
    run_one(32'd359);
    run_one(32'd270);
    run_one(32'd271);
    run_one(32'd187);
    run_one(32'd0);

    start_and_wait(32'd120);
    held = bus.out_sin;
    stable = 1'b1;
    bus.in_angle = 32'd5;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_sin !== held ||
          bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("backpressure_stable", stable, 1'b1);
    chk("backpressure_busy", busy, 1'b1);
    chk("backpressure_sin", bus.out_sin,
        ref_sin(32'd120));
    bus.in_valid = 1'b0;
    handshake();

    bus.in_angle = 32'd1000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("busy_in_reduce", busy, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_in_ready_low",
        bus.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    run_one(32'd45);

    for (int i = 0; i < 16; i++)
      run_one($urandom);
    for (int i = 0; i < 8; i++)
      run_one($urandom_range(0, 719));

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    if (fails == 0)
      $display("PASS");
    else
      $display("FAIL");
    $finish;
  end

endmodule
